// File: rtl/multi_pipe_game_controller_if.sv
// Bus between the game controller, the bird-physics block (bird_y, buttons)
// and the VGA renderer (pipe positions, score, state).
`timescale 1ns/1ps
interface multi_pipe_game_controller_if #(
  parameter int NUM_PIPES = 3,
  parameter int X_W       = 11,
  parameter int SCORE_W   = 10
) ();
  logic                      frame_tick;
  logic                      start_button;
  logic [9:0]                bird_y;
  logic [NUM_PIPES*X_W-1:0]  pipe_x_flat;
  logic [NUM_PIPES*10-1:0]   gap_y_flat;
  logic [SCORE_W-1:0]        score;
  logic [3:0]                speed;
  logic                      collision_out;
  logic [1:0]                state;

  modport master (
    output frame_tick, start_button, bird_y,
    input  pipe_x_flat, gap_y_flat, score, speed, collision_out, state
  );

  modport slave (
    input  frame_tick, start_button, bird_y,
    output pipe_x_flat, gap_y_flat, score, speed, collision_out, state
  );
endinterface

// File: rtl/multi_pipe_game_controller.sv
// Flappy-style game controller: scrolls NUM_PIPES pipe columns on frame_tick,
// draws gaps from an LFSR, detects collisions, keeps score and speed level.
`timescale 1ns/1ps
module multi_pipe_game_controller #(
  parameter int NUM_PIPES     = 3,
  parameter int X_W           = 11,
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int PIPE_WIDTH    = 30,
  parameter int GAP_HEIGHT    = 100,
  parameter int GAP_MIN       = 40,
  parameter int GAP_MASK      = 255,
  parameter int PIPE_SPACING  = 240,
  parameter int BIRD_X        = 200,
  parameter int BIRD_WIDTH    = 20,
  parameter int BIRD_HEIGHT   = 20,
  parameter int SPEED_INIT    = 4,
  parameter int SPEED_MAX     = 12,
  parameter int LEVEL_PIPES   = 5,
  parameter int SCORE_W       = 10
) (
  input logic                        clk,
  input logic                        reset,
  multi_pipe_game_controller_if.slave bus
);

  localparam logic [1:0] ST_IDLE      = 2'b00;
  localparam logic [1:0] ST_PLAY      = 2'b01;
  localparam logic [1:0] ST_GAME_OVER = 2'b10;

  localparam int CW    = (X_W > 11) ? X_W + 1 : 12;
  localparam int SPAN  = NUM_PIPES * PIPE_SPACING;
  localparam int LVL_W = $clog2(LEVEL_PIPES + 1);

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [9:0]         GAP_INIT  = 10'(GAP_MIN);
  localparam logic [15:0]        LFSR_SEED = 16'hACE1;

  if (NUM_PIPES * PIPE_SPACING < SCREEN_WIDTH + PIPE_WIDTH) begin : g_bad_spacing
    $error("pipe columns do not cover the screen");
  end
  if (GAP_MIN + GAP_MASK + GAP_HEIGHT > SCREEN_HEIGHT) begin : g_bad_gap
    $error("gap range exceeds the screen height");
  end
  if (SCREEN_WIDTH + (NUM_PIPES - 1) * PIPE_SPACING >= (1 << X_W)) begin : g_bad_xw
    $error("initial pipe x does not fit in X_W");
  end
  if (PIPE_SPACING <= SPEED_MAX || SPEED_MAX > 15 || SPEED_INIT < 1 || SPEED_INIT > SPEED_MAX) begin : g_bad_speed
    $error("illegal speed configuration");
  end

  logic [1:0]         state_q;
  logic [X_W-1:0]     pipe_x_q   [NUM_PIPES];
  logic [9:0]         gap_y_q    [NUM_PIPES];
  logic [X_W-1:0]     pipe_x_nxt [NUM_PIPES];
  logic               pipe_hit   [NUM_PIPES];
  logic               pipe_pass  [NUM_PIPES];
  logic               pipe_wrap  [NUM_PIPES];
  logic [SCORE_W-1:0] score_q;
  logic [3:0]         speed_q;
  logic [LVL_W-1:0]   level_q;
  logic               collision_q;
  logic [15:0]        lfsr_q;

  logic [CW-1:0]              bird_top, bird_bot;
  logic                       floor_hit, crash, scored, lfsr_fb;
  logic [9:0]                 gap_new;
  logic [NUM_PIPES*X_W-1:0]   pipe_x_flat;
  logic [NUM_PIPES*10-1:0]    gap_y_flat;

  assign bird_top  = CW'(bus.bird_y);
  assign bird_bot  = bird_top + CW'(BIRD_HEIGHT);
  assign floor_hit = bird_bot > CW'(SCREEN_HEIGHT);
  assign gap_new   = GAP_INIT + (lfsr_q[9:0] & 10'(GAP_MASK));
  assign lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // All geometry is widened to CW bits so sums never wrap.
  for (genvar g = 0; g < NUM_PIPES; g++) begin : g_pipe
    logic [CW-1:0] px, px_moved, gap_top;
    logic          overlap, outside;
    assign px       = CW'(pipe_x_q[g]);
    assign px_moved = px - CW'(speed_q);
    assign gap_top  = CW'(gap_y_q[g]);
    assign overlap  = (px < CW'(BIRD_X + BIRD_WIDTH)) && ((px + CW'(PIPE_WIDTH)) > CW'(BIRD_X));
    assign outside  = (bird_top < gap_top) || (bird_bot > gap_top + CW'(GAP_HEIGHT));
    assign pipe_wrap[g]  = px <= CW'(speed_q);
    assign pipe_hit[g]   = overlap && outside;
    assign pipe_pass[g]  = !pipe_wrap[g] && ((px + CW'(PIPE_WIDTH)) >= CW'(BIRD_X))
                           && ((px_moved + CW'(PIPE_WIDTH)) < CW'(BIRD_X));
    assign pipe_x_nxt[g] = pipe_wrap[g] ? X_W'(px + CW'(SPAN) - CW'(speed_q)) : X_W'(px_moved);
  end

  // NOTE: every output of a combinational block gets a default at the top so no path can infer a latch.
  always_comb begin
    crash       = floor_hit;
    scored      = 1'b0;
    pipe_x_flat = '0;
    gap_y_flat  = '0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      crash  = crash | pipe_hit[i];
      scored = scored | pipe_pass[i];
      pipe_x_flat[i*X_W +: X_W] = pipe_x_q[i];
      gap_y_flat[i*10 +: 10]    = gap_y_q[i];
    end
  end

  // Pipes stay PIPE_SPACING apart and PIPE_SPACING > SPEED_MAX, so at most one
  // trailing edge crosses the bird per tick and the score moves by one at most.
  // level_q tracks score modulo LEVEL_PIPES without a divider.
  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the pipe/gap arrays are a handful of flops, not RAM, so they take the async reset like any other state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      score_q     <= '0;
      speed_q     <= 4'(SPEED_INIT);
      level_q     <= '0;
      collision_q <= 1'b0;
      lfsr_q      <= LFSR_SEED;
      for (int i = 0; i < NUM_PIPES; i++) begin
        pipe_x_q[i] <= X_W'(SCREEN_WIDTH + i * PIPE_SPACING);
        gap_y_q[i]  <= GAP_INIT;
      end
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_fb};
      case (state_q)
        ST_IDLE: begin
          if (bus.start_button) state_q <= ST_PLAY;
        end
        ST_PLAY: begin
          if (bus.frame_tick) begin
            if (crash) begin
              collision_q <= 1'b1;
              state_q     <= ST_GAME_OVER;
            end else begin
              for (int i = 0; i < NUM_PIPES; i++) begin
                pipe_x_q[i] <= pipe_x_nxt[i];
                if (pipe_wrap[i]) gap_y_q[i] <= gap_new;
              end
              if (scored && score_q != SCORE_MAX) begin
                score_q <= score_q + SCORE_W'(1);
                if (level_q == LVL_W'(LEVEL_PIPES - 1)) begin
                  level_q <= '0;
                  if (speed_q < 4'(SPEED_MAX)) speed_q <= speed_q + 4'd1;
                end else begin
                  level_q <= level_q + LVL_W'(1);
                end
              end
            end
          end
        end
        ST_GAME_OVER: begin
          if (bus.start_button) begin
            state_q     <= ST_IDLE;
            score_q     <= '0;
            speed_q     <= 4'(SPEED_INIT);
            level_q     <= '0;
            collision_q <= 1'b0;
            for (int i = 0; i < NUM_PIPES; i++) begin
              pipe_x_q[i] <= X_W'(SCREEN_WIDTH + i * PIPE_SPACING);
              gap_y_q[i]  <= GAP_INIT;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.pipe_x_flat   = pipe_x_flat;
  assign bus.gap_y_flat    = gap_y_flat;
  assign bus.score         = score_q;
  assign bus.speed         = speed_q;
  assign bus.collision_out = collision_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_multi_pipe_game_controller.sv
// Scoreboarded bench for multi_pipe_game_controller: a per-cycle game model
// queues expected snapshots; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_multi_pipe_game_controller;

  localparam int NP        = 3;
  localparam int XW        = 11;
  localparam int SW        = 10;
  localparam int SCR_W     = 640;
  localparam int SCR_H     = 480;
  localparam int PW        = 30;
  localparam int GH        = 100;
  localparam int GMIN      = 40;
  localparam int GMASK     = 255;
  localparam int SPACING   = 240;
  localparam int BX        = 200;
  localparam int BW        = 20;
  localparam int BH        = 20;
  localparam int SPD_INIT  = 4;
  localparam int SPD_MAX   = 12;
  localparam int LEVEL     = 5;
  localparam int SCORE_TOP = (1 << SW) - 1;

  typedef struct packed {
    logic [1:0]            state;
    logic [SW-1:0]         score;
    logic [3:0]            speed;
    logic                  coll;
    logic [NP-1:0][XW-1:0] px;
    logic [NP-1:0][9:0]    gy;
  } snap_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  multi_pipe_game_controller_if #(.NUM_PIPES(NP), .X_W(XW), .SCORE_W(SW)) bus ();
  multi_pipe_game_controller dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Reference game state, plain integers.
  int          m_px [NP];
  int          m_gy [NP];
  int          m_score, m_speed, m_state, m_coll;
  logic [15:0] m_lfsr;
  snap_t       exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    int   taps [4] = '{16, 14, 13, 11};
    logic fb = 1'b0;
    foreach (taps[k]) fb = fb ^ v[taps[k]-1];
    return {v[14:0], fb};
  endfunction

  task automatic model_init(input bit with_lfsr);
    for (int i = 0; i < NP; i++) begin
      m_px[i] = SCR_W + i * SPACING;
      m_gy[i] = GMIN;
    end
    m_score = 0;
    m_speed = SPD_INIT;
    m_state = 0;
    m_coll  = 0;
    if (with_lfsr) m_lfsr = 16'hACE1;
  endtask

  task automatic model_step();
    logic [15:0] l = m_lfsr;
    int          by = int'(bus.bird_y);
    int          passed = 0;
    bit          crash;
    case (m_state)
      0: if (bus.start_button) m_state = 1;
      1: if (bus.frame_tick) begin
        crash = (by + BH > SCR_H);
        for (int i = 0; i < NP; i++)
          if (m_px[i] < BX + BW && m_px[i] + PW > BX && (by < m_gy[i] || by + BH > m_gy[i] + GH))
            crash = 1'b1;
        if (crash) begin
          m_coll  = 1;
          m_state = 2;
        end else begin
          for (int i = 0; i < NP; i++) begin
            if (m_px[i] <= m_speed) begin
              m_px[i] = m_px[i] + NP * SPACING - m_speed;
              m_gy[i] = GMIN + (int'(l) & GMASK);
            end else begin
              int old = m_px[i];
              m_px[i] = old - m_speed;
              if (old + PW >= BX && m_px[i] + PW < BX) passed++;
            end
          end
          if (passed > 0 && m_score < SCORE_TOP) begin
            m_score = (m_score + passed > SCORE_TOP) ? SCORE_TOP : m_score + passed;
            if (m_score % LEVEL == 0) m_speed = (m_speed + 1 > SPD_MAX) ? SPD_MAX : m_speed + 1;
          end
        end
      end
      2: if (bus.start_button) model_init(1'b0);
      default: m_state = 0;
    endcase
    m_lfsr = lfsr_next(l);
  endtask

  function automatic snap_t snapshot();
    snap_t s;
    s.state = 2'(m_state);
    s.score = SW'(m_score);
    s.speed = 4'(m_speed);
    s.coll  = m_coll[0];
    for (int i = 0; i < NP; i++) begin
      s.px[i] = XW'(m_px[i]);
      s.gy[i] = 10'(m_gy[i]);
    end
    return s;
  endfunction

  // Model: advances on every clock edge, pushes an expectation whenever the
  // cycle carried a tick or a button press.
  initial begin
    model_init(1'b1);
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        model_init(1'b1);
        exp_q.delete();
      end else begin
        model_step();
        if (bus.frame_tick || bus.start_button) exp_q.push_back(snapshot());
      end
    end
  end

  // Monitor: compares the DUT against the oldest expectation on the falling edge.
  initial begin
    snap_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_state", 32'(bus.state), 32'(e.state));
        check("sb_score", 32'(bus.score), 32'(e.score));
        check("sb_speed", 32'(bus.speed), 32'(e.speed));
        check("sb_collision", 32'(bus.collision_out), 32'(e.coll));
        for (int i = 0; i < NP; i++) begin
          check($sformatf("sb_pipe_x%0d", i), 32'(bus.pipe_x_flat[i*XW +: XW]), 32'(e.px[i]));
          check($sformatf("sb_gap_y%0d", i), 32'(bus.gap_y_flat[i*10 +: 10]), 32'(e.gy[i]));
        end
      end
    end
  end

  function automatic logic [9:0] pilot_y();
    int best = 0;
    int bx   = 1 << 30;
    for (int i = 0; i < NP; i++)
      if (m_px[i] + PW > BX && m_px[i] < bx) begin
        bx   = m_px[i];
        best = i;
      end
    return 10'(m_gy[best] + 40);
  endfunction

  task automatic do_tick(input bit pilot, input logic [9:0] y);
    @(negedge clk);
    bus.bird_y     = pilot ? pilot_y() : y;
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
  endtask

  task automatic press_start();
    @(negedge clk);
    bus.start_button = 1'b1;
    @(negedge clk);
    bus.start_button = 1'b0;
  endtask

  function automatic int dut_px(input int i);
    return int'(bus.pipe_x_flat[i*XW +: XW]);
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, 32'(bus.state), 0);
    check({tag, "_score"}, 32'(bus.score), 0);
    check({tag, "_speed"}, 32'(bus.speed), SPD_INIT);
    check({tag, "_collision"}, 32'(bus.collision_out), 0);
    for (int i = 0; i < NP; i++) begin
      check($sformatf("%s_pipe_x%0d", tag, i), 32'(dut_px(i)), SCR_W + i * SPACING);
      check($sformatf("%s_gap_y%0d", tag, i), 32'(bus.gap_y_flat[i*10 +: 10]), GMIN);
    end
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    summary();
    $finish;
  end

  initial begin
    int g;
    reset            = 1'b1;
    bus.frame_tick   = 1'b0;
    bus.start_button = 1'b0;
    bus.bird_y       = 10'd60;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_values("post_reset");

    // Ticks without PLAY are ignored.
    repeat (50) do_tick(1'b0, 10'd60);
    check_reset_values("idle_hold");

    press_start();
    check("start_to_play", 32'(bus.state), 1);
    repeat (10) do_tick(1'b0, 10'd60);
    check("tick10_pipe0", 32'(dut_px(0)), 600);
    check("tick10_pipe1", 32'(dut_px(1)), 840);
    check("tick10_pipe2", 32'(dut_px(2)), 1080);

    repeat (107) do_tick(1'b0, 10'd60);
    check("tick117_pipe0", 32'(dut_px(0)), 172);
    check("tick117_score", 32'(bus.score), 0);
    do_tick(1'b0, 10'd60);
    check("tick118_pipe0", 32'(dut_px(0)), 168);
    check("tick118_score", 32'(bus.score), 1);
    check("tick118_collision", 32'(bus.collision_out), 0);
    check("tick118_speed", 32'(bus.speed), SPD_INIT);

    // Pipe 0 lands exactly on speed, then wraps with a fresh gap.
    repeat (41) do_tick(1'b0, 10'd60);
    check("tick159_pipe0", 32'(dut_px(0)), 4);
    do_tick(1'b0, 10'd60);
    check("wrap_pipe0", 32'(dut_px(0)), 720);
    g = int'(bus.gap_y_flat[9:0]);
    check("wrap_gap_range", 32'(g >= 40 && g <= 295), 1);

    // Fly through the gaps until two speed levels have been earned.
    for (int t = 0; t < 4000 && m_score < 11; t++) do_tick(1'b1, 10'd0);
    check("level_score", 32'(bus.score), 11);
    check("level_speed", 32'(bus.speed), 6);

    // Asynchronous reset asserted mid-tick, checked before the next clock edge.
    @(negedge clk);
    bus.frame_tick = 1'b1;
    #2 reset = 1'b1;
    #1 check_reset_values("async_reset");
    @(negedge clk);
    bus.frame_tick = 1'b0;
    reset = 1'b0;

    // Pipe collision with bird_y=300.
    press_start();
    repeat (106) do_tick(1'b0, 10'd300);
    check("tick106_pipe0", 32'(dut_px(0)), 216);
    check("tick106_state", 32'(bus.state), 1);
    do_tick(1'b0, 10'd300);
    check("crash_collision", 32'(bus.collision_out), 1);
    check("crash_state", 32'(bus.state), 2);
    check("crash_pipe0", 32'(dut_px(0)), 216);
    repeat (5) do_tick(1'b0, 10'd300);
    check("over_hold_pipe0", 32'(dut_px(0)), 216);
    check("over_hold_collision", 32'(bus.collision_out), 1);

    press_start();
    check_reset_values("reinit");

    // Floor collision on the first tick.
    press_start();
    do_tick(1'b0, 10'd470);
    check("floor_state", 32'(bus.state), 2);
    check("floor_collision", 32'(bus.collision_out), 1);
    check("floor_pipe0", 32'(dut_px(0)), SCR_W);
    press_start();

    // Random phase: random ticks, restarts and occasional off-course flight.
    repeat (3000) begin
      @(negedge clk);
      bus.frame_tick   = ($urandom_range(0, 2) == 0);
      bus.start_button = ($urandom_range(0, 24) == 0);
      bus.bird_y       = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(0, 479)) : pilot_y();
    end
    @(negedge clk);
    bus.frame_tick   = 1'b0;
    bus.start_button = 1'b0;
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    summary();
    $finish;
  end

endmodule
